// File: rtl/norm_pkg.sv
// norm_pkg: shared definitions for the normalizer pipeline.
//   norm_mode_e : NORM_LZ counts leading zeros, NORM_LS counts redundant sign bits.
//   cnt_w()     : width of a shift count that can represent 0..WIDTH.
package norm_pkg;

  typedef enum logic {
    NORM_LZ = 1'b0,
    NORM_LS = 1'b1
  } norm_mode_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// lzc_tree: combinational leading-zero / leading-sign counter, log-depth tree.
//   i_data [WIDTH]     value to scan from bit WIDTH-1 downwards
//   i_mode             NORM_LZ or NORM_LS
//   o_cnt  [CW]        NORM_LZ: leading zeros (WIDTH when all zero)
//                      NORM_LS: bits below the MSB equal to the MSB (max WIDTH-1)
//   o_zero             no significant bit (all zero, or all-equal in sign mode)
module lzc_tree
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]            i_data,
  input  norm_mode_e                  i_mode,
  output logic [cnt_w(WIDTH)-1:0]     o_cnt,
  output logic                        o_zero
);

  localparam int unsigned LOG = $clog2(WIDTH);
  localparam int unsigned CW  = LOG + 1;

  logic [WIDTH-2:0] w_sign_diff;
  logic [WIDTH-1:0] w_scan;
  logic             w_any;
  logic [LOG-1:0]   w_tree_cnt;

  // Sign mode becomes a leading-zero count of (bits below MSB xor MSB); the
  // appended 1 caps the count at WIDTH-1 when every bit matches the MSB.
  assign w_sign_diff = i_data[WIDTH-2:0] ^ {(WIDTH-1){i_data[WIDTH-1]}};
  assign w_scan      = (i_mode == NORM_LS) ? {w_sign_diff, 1'b1} : i_data;

  // Node i at level l covers 2^l bits; node 2i+1 is the more significant half.
  // Each level overwrites lower indices only after their sources were read.
  always_comb begin
    logic [WIDTH/2-1:0] w_v;
    logic [LOG-1:0]     w_c [WIDTH/2];
    logic [LOG-1:0]     w_sel;
    w_v   = '0;
    w_sel = '0;
    for (int unsigned i = 0; i < WIDTH/2; i++) begin
      w_v[i]    = w_scan[2*i+1] | w_scan[2*i];
      w_c[i]    = '0;
      w_c[i][0] = ~w_scan[2*i+1];
    end
    for (int unsigned l = 2; l <= LOG; l++) begin
      for (int unsigned i = 0; i < (WIDTH >> l); i++) begin
        w_sel        = w_v[2*i+1] ? w_c[2*i+1] : w_c[2*i];
        w_sel[l-1]   = ~w_v[2*i+1];
        w_c[i]       = w_sel;
        w_v[i]       = w_v[2*i+1] | w_v[2*i];
      end
    end
    w_any      = w_v[0];
    w_tree_cnt = w_c[0];
  end

  assign o_cnt  = w_any ? {1'b0, w_tree_cnt} : CW'(WIDTH);
  assign o_zero = (i_mode == NORM_LS) ? (w_sign_diff == '0) : ~w_any;

endmodule

// File: rtl/norm_pipe.sv
// norm_pipe: pipelined normalizer with valid/ready handshakes on both sides.
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data [WIDTH]       unnormalized value
//   in_mode               0 = leading-zero, 1 = leading-sign
//   in_tag  [TAGW]        sideband tag, carried unchanged
//   out_valid/out_ready   output handshake
//   out_norm [WIDTH]      in_data shifted left by out_cnt, zero-filled
//   out_cnt  [CW]         shift count applied
//   out_zero              input had no significant bit
//   out_tag  [TAGW]       tag of the same transaction
// STAGES = 2: stage 1 holds count/mode/data/tag, stage 2 holds the shifted result.
// STAGES = 1: count and shift in one cycle into the output register.
module norm_pipe
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAGW   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_mode,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_norm,
  output logic [cnt_w(WIDTH)-1:0] out_cnt,
  output logic                    out_zero,
  output logic [TAGW-1:0]         out_tag
);

  localparam int unsigned CW = cnt_w(WIDTH);

  norm_mode_e       w_mode;
  logic [CW-1:0]    w_cnt;
  logic             w_zero;
  logic             w_out_free;

  logic [WIDTH-1:0] w_sh_data;
  logic [CW-1:0]    w_sh_cnt;
  norm_mode_e       w_sh_mode;
  logic             w_sh_zero;
  logic [WIDTH-1:0] w_norm;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_norm;
  logic [CW-1:0]    r_out_cnt;
  logic             r_out_zero;
  logic [TAGW-1:0]  r_out_tag;

  assign w_mode = norm_mode_e'(in_mode);

  lzc_tree #(.WIDTH(WIDTH)) u_lzc (
    .i_data (in_data),
    .i_mode (w_mode),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  // Output register accepts a new value when empty or being drained.
  assign w_out_free = ~r_out_valid | out_ready;

  // An all-zero word in leading-zero mode shifts by WIDTH: force zero explicitly.
  assign w_norm = ((w_sh_mode == NORM_LZ) && w_sh_zero) ? '0 : (w_sh_data << w_sh_cnt);

  if (STAGES == 1) begin : g_one
    assign w_sh_data = in_data;
    assign w_sh_cnt  = w_cnt;
    assign w_sh_mode = w_mode;
    assign w_sh_zero = w_zero;
    assign in_ready  = w_out_free;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out_valid <= 1'b0;
        r_out_norm  <= '0;
        r_out_cnt   <= '0;
        r_out_zero  <= 1'b0;
        r_out_tag   <= '0;
      end else if (w_out_free) begin
        r_out_valid <= in_valid;
        if (in_valid) begin
          r_out_norm <= w_norm;
          r_out_cnt  <= w_cnt;
          r_out_zero <= w_zero;
          r_out_tag  <= in_tag;
        end
      end
    end
  end else begin : g_two
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [CW-1:0]    r_s1_cnt;
    norm_mode_e       r_s1_mode;
    logic             r_s1_zero;
    logic [TAGW-1:0]  r_s1_tag;

    assign in_ready  = ~r_s1_valid | w_out_free;
    assign w_sh_data = r_s1_data;
    assign w_sh_cnt  = r_s1_cnt;
    assign w_sh_mode = r_s1_mode;
    assign w_sh_zero = r_s1_zero;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1_valid <= 1'b0;
        r_s1_data  <= '0;
        r_s1_cnt   <= '0;
        r_s1_mode  <= NORM_LZ;
        r_s1_zero  <= 1'b0;
        r_s1_tag   <= '0;
      end else if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= in_data;
          r_s1_cnt  <= w_cnt;
          r_s1_mode <= w_mode;
          r_s1_zero <= w_zero;
          r_s1_tag  <= in_tag;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out_valid <= 1'b0;
        r_out_norm  <= '0;
        r_out_cnt   <= '0;
        r_out_zero  <= 1'b0;
        r_out_tag   <= '0;
      end else if (w_out_free) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_norm <= w_norm;
          r_out_cnt  <= r_s1_cnt;
          r_out_zero <= r_s1_zero;
          r_out_tag  <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_norm  = r_out_norm;
  assign out_cnt   = r_out_cnt;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_norm_pipe.sv
// tb_norm_pipe: directed checks of norm_pipe (64-bit two-stage instance and an
// 8-bit single-stage instance sharing clock and reset).
module tb_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
  logic [63:0] in_data, out_norm;
  logic [3:0]  in_tag, out_tag;
  logic [6:0]  out_cnt;

  logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_zero;
  logic [7:0]  s_in_data, s_out_norm;
  logic [3:0]  s_in_tag, s_out_tag;
  logic [3:0]  s_out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  norm_pipe #(.WIDTH(64), .STAGES(2), .TAGW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_norm(out_norm),
    .out_cnt(out_cnt), .out_zero(out_zero), .out_tag(out_tag)
  );

  norm_pipe #(.WIDTH(8), .STAGES(1), .TAGW(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_mode(s_in_mode), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_norm(s_out_norm),
    .out_cnt(s_out_cnt), .out_zero(s_out_zero), .out_tag(s_out_tag)
  );

  // Directed vectors for the 64-bit instance: data, mode, count, normalized, zero.
  logic [63:0] v_data [14] = '{
    64'h0000_0001_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF0_0000_0000_0000,
    64'h8000_0000_0000_0000, 64'h0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001,
    64'h4000_0000_0000_0000, 64'h0000_0000_00F0_1234, 64'h8000_0000_0000_0000,
    64'hC000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF};
  logic        v_mode [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [6:0]  v_cnt  [14] = '{7'd31, 7'd64, 7'd63, 7'd11, 7'd0, 7'd63, 7'd62,
                               7'd63, 7'd0, 7'd40, 7'd0, 7'd1, 7'd62, 7'd1};
  logic [63:0] v_norm [14] = '{
    64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
    64'h8000_0000_0000_0000, 64'h0, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000,
    64'h4000_0000_0000_0000, 64'hF012_3400_0000_0000, 64'h8000_0000_0000_0000,
    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
  logic        v_zero [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1; in_data = 64'h0000_0000_0001_0000; in_tag = 4'hA; out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_data = 8'h01; s_in_tag = 4'h5; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_norm !== 64'h0) begin n_fail++; $display("FAIL reset_out_norm: got %h want 0", out_norm); end
    n_tests++; if (out_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt); end
    n_tests++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
    n_tests++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s1_out_valid: got %b want 0", s_out_valid); end
    n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s1_in_ready: got %b want 1", s_in_ready); end
    in_valid = 1'b0; s_in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_data = v_data[i]; in_mode = v_mode[i]; in_tag = 4'(i);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the transaction must keep its sampled values.
      in_valid = 1'b0; in_data = ~in_data; in_mode = ~in_mode; in_tag = ~in_tag;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_early_valid[%0d]: got %b want 0", i, out_valid); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec_valid[%0d]: got %b want 1", i, out_valid); end
      n_tests++; if (out_cnt !== v_cnt[i]) begin n_fail++; $display("FAIL vec_cnt[%0d]: got %0d want %0d", i, out_cnt, v_cnt[i]); end
      n_tests++; if (out_norm !== v_norm[i]) begin n_fail++; $display("FAIL vec_norm[%0d]: got %h want %h", i, out_norm, v_norm[i]); end
      n_tests++; if (out_zero !== v_zero[i]) begin n_fail++; $display("FAIL vec_zero[%0d]: got %b want %b", i, out_zero, v_zero[i]); end
      n_tests++; if (out_tag !== 4'(i)) begin n_fail++; $display("FAIL vec_tag[%0d]: got %h want %h", i, out_tag, 4'(i)); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_drained[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; in_data = 64'h1 << (10 * k); in_mode = 1'b0; in_tag = 4'(8 + k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 4) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
      end
      @(posedge clk); #1;
      if (k >= 1 && k <= 4) begin
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); end
        n_tests++; if (out_tag !== 4'(7 + k)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %h want %h", k, out_tag, 4'(7 + k)); end
        n_tests++; if (out_cnt !== 7'(73 - 10 * k)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", k, out_cnt, 73 - 10 * k); end
      end else begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b want 0", k, out_valid); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          got  = 0;
    int          occ  = 0;
    logic        saw_block = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] p_norm = '0;
    logic [6:0]  p_cnt = '0;
    logic        p_zero = 1'b0;
    logic [3:0]  p_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = 64'h1 << (7 * sent + 3);
      in_mode   = 1'b0;
      in_tag    = 4'(sent);
      out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_norm !== p_norm || out_cnt !== p_cnt ||
            out_zero !== p_zero || out_tag !== p_tag) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got v=%b tag=%h cnt=%0d want v=1 tag=%h cnt=%0d",
                   cyc, out_valid, out_tag, out_cnt, p_tag, p_cnt);
        end
      end
      n_tests++; if (in_ready !== ((occ < 2) || out_ready)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, in_ready, (occ < 2) || out_ready); end
      if (occ == 0) begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_spurious[%0d]: got %b want 0", cyc, out_valid); end
      end
      if (in_ready === 1'b0) saw_block = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        n_tests++; if (out_tag !== 4'(got)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", cyc, out_tag, 4'(got)); end
        n_tests++; if (out_cnt !== 7'(60 - 7 * got)) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d want %0d", cyc, out_cnt, 60 - 7 * got); end
        n_tests++; if (out_norm !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL bp_norm[%0d]: got %h want 8000000000000000", cyc, out_norm); end
        got++; occ--;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      p_norm = out_norm; p_cnt = out_cnt; p_zero = out_zero; p_tag = out_tag;
      if (in_valid && in_ready === 1'b1) begin sent++; occ++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
    n_tests++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 1", saw_block); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h1 << 5; in_mode = 1'b0; in_tag = 4'h3;
    @(posedge clk); #1;
    in_data = 64'h1 << 9; in_tag = 4'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full_valid: got %b want 1", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_ready: got %b want 0", in_ready); end
    #1 reset_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    n_tests++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL mid_rst_tag: got %h want 0", out_tag); end
    n_tests++; if (out_cnt !== 7'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", out_cnt); end
    n_tests++; if (out_norm !== 64'h0) begin n_fail++; $display("FAIL mid_rst_norm: got %h want 0", out_norm); end
    out_ready = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b1;
    in_valid = 1'b1; in_data = 64'h1 << 20; in_mode = 1'b0; in_tag = 4'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_valid: got %b want 1", out_valid); end
    n_tests++; if (out_tag !== 4'h9) begin n_fail++; $display("FAIL mid_first_tag: got %h want 9", out_tag); end
    n_tests++; if (out_cnt !== 7'd43) begin n_fail++; $display("FAIL mid_first_cnt: got %0d want 43", out_cnt); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_extra: got %b want 0", out_valid); end
  endtask

  task automatic test_stages1();
    logic [7:0] d [4] = '{8'h01, 8'h80, 8'h00, 8'hFF};
    logic       m [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] c [4] = '{4'd7, 4'd0, 4'd8, 4'd7};
    logic [7:0] n [4] = '{8'h80, 8'h80, 8'h00, 8'h80};
    logic       z [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    s_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        s_in_valid = 1'b1; s_in_data = d[k]; s_in_mode = m[k]; s_in_tag = 4'(k + 1);
        #1;
        n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL s1_in_ready[%0d]: got %b want 1", k, s_in_ready); end
      end else begin
        s_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        n_tests++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid[%0d]: got %b want 1", k, s_out_valid); end
        n_tests++; if (s_out_cnt !== c[k]) begin n_fail++; $display("FAIL s1_cnt[%0d]: got %0d want %0d", k, s_out_cnt, c[k]); end
        n_tests++; if (s_out_norm !== n[k]) begin n_fail++; $display("FAIL s1_norm[%0d]: got %h want %h", k, s_out_norm, n[k]); end
        n_tests++; if (s_out_zero !== z[k]) begin n_fail++; $display("FAIL s1_zero[%0d]: got %b want %b", k, s_out_zero, z[k]); end
        n_tests++; if (s_out_tag !== 4'(k + 1)) begin n_fail++; $display("FAIL s1_tag[%0d]: got %h want %h", k, s_out_tag, 4'(k + 1)); end
      end else begin
        n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL s1_idle: got %b want 0", s_out_valid); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = 1'b0; s_in_tag = '0; s_out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_stages1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
